// File: rtl/multi_wave_plotter.sv
// Multi-channel scope plotter: box-car averages codec samples per channel, optional rising-edge
// trigger on channel 0, then draws, holds and erases the traces through the VGA framebuffer.
module multi_wave_plotter #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned NCH         = 2,
  parameter int unsigned BUFFER_SIZE = 640,
  parameter int unsigned LOG2_AVG    = 11,
  parameter int unsigned DIV         = 15,
  parameter int          Y_MID       = 240,
  parameter int          Y_MAX       = 479,
  parameter int unsigned HOLD        = 16384,
  parameter int unsigned ARM_TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       enable,
  input  logic [NCH*WIDTH-1:0]       samples,
  input  logic [NCH-1:0]             ch_mask,
  input  logic                       trig_mode,
  input  logic [WIDTH-1:0]           trig_level,
  output logic [9:0]                 x,
  output logic [8:0]                 y,
  output logic [$clog2(NCH+1)-1:0]   pen,
  output logic                       pixel_write,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int unsigned AW   = WIDTH + LOG2_AVG;
  localparam int unsigned CNTW = LOG2_AVG + 1;
  localparam int unsigned IW   = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW   = $clog2(NCH + 1);

  localparam logic [CNTW-1:0]        AVG_LAST = CNTW'((1 << LOG2_AVG) - 1);
  localparam logic [IW-1:0]          IDX_LAST = IW'(BUFFER_SIZE - 1);
  localparam logic [31:0]            HOLD_LAST = 32'(HOLD - 1);
  localparam logic [31:0]            ARM_LAST  = 32'(ARM_TIMEOUT - 1);
  localparam logic signed [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StArm, StCapture, StDraw, StHold, StErase} state_e;

  state_e state_q, state_d;

  logic [NCH-1:0]          mask_q;
  logic signed [AW-1:0]    acc_q [NCH];
  logic [CNTW-1:0]         avg_cnt_q;
  logic [IW-1:0]           idx_q;
  logic signed [WIDTH-1:0] prev_q;
  logic [31:0]             arm_cnt_q;
  logic [31:0]             hold_cnt_q;
  logic [CW-1:0]           wch_q;
  logic [IW-1:0]           wi_q;
  logic                    wact_q;
  logic [8:0]              mem [NCH][BUFFER_SIZE];

  logic signed [WIDTH-1:0] ch0, level_s;
  logic signed [AW-1:0]    sum [NCH];
  logic [8:0]              ypt [NCH];
  logic                    strobe_arm, trig, timeout, take, point, cap_done;
  logic                    launch, walk_load, nxt_found, drawing;
  logic [CW-1:0]           nxt_ch, first_ch;

  assign busy    = (state_q != StIdle);
  assign level_s = trig_level;
  assign ch0     = samples[WIDTH-1:0];
  assign drawing = (state_q == StDraw) || (state_q == StErase);

  always_comb begin
    strobe_arm = (state_q == StArm) && enable;
    // The first strobe in ARM has no genuine predecessor, so it never triggers.
    trig       = strobe_arm && (arm_cnt_q != '0) && (prev_q < level_s) && (ch0 >= level_s);
    timeout    = strobe_arm && !trig && (arm_cnt_q == ARM_LAST);
    take       = ((state_q == StCapture) && enable) || trig;
    point      = take && (avg_cnt_q == AVG_LAST);
    cap_done   = point && (idx_q == IDX_LAST);
  end

  always_comb begin
    logic signed [AW-1:0] avg;
    logic signed [31:0]   yv;
    avg = '0;
    yv  = '0;
    for (int c = 0; c < NCH; c++) begin
      sum[c] = acc_q[c] + AW'(signed'(samples[c*WIDTH +: WIDTH]));
      avg    = sum[c] >>> LOG2_AVG;
      yv     = Y_MID - 32'(avg >>> DIV);
      if (yv < 0)          ypt[c] = '0;
      else if (yv > Y_MAX) ypt[c] = 9'(Y_MAX);
      else                 ypt[c] = yv[8:0];
    end
  end

  // Lowest enabled channel overall, and lowest enabled channel above the one being walked.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    first_ch  = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (mask_q[c]) begin
        first_ch = CW'(c);
        if (c > int'(wch_q)) begin
          nxt_found = 1'b1;
          nxt_ch    = CW'(c);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = trig_mode ? StArm : StCapture;
      StArm: begin
        if (cap_done)             state_d = (mask_q != '0) ? StDraw : StHold;
        else if (trig || timeout) state_d = StCapture;
      end
      StCapture: if (cap_done) state_d = (mask_q != '0) ? StDraw : StHold;
      StDraw:    if (!wact_q) state_d = StHold;
      StHold:    if (hold_cnt_q == HOLD_LAST) state_d = StErase;
      StErase: begin
        if (!wact_q) state_d = start ? (trig_mode ? StArm : StCapture) : StIdle;
      end
      default:   state_d = StIdle;
    endcase
    launch    = start && ((state_q == StIdle) || ((state_q == StErase) && !wact_q));
    walk_load = ((state_d == StDraw) && (state_q != StDraw)) ||
                ((state_d == StErase) && (state_q != StErase));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      avg_cnt_q  <= '0;
      idx_q      <= '0;
      prev_q     <= '0;
      arm_cnt_q  <= '0;
      hold_cnt_q <= '0;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
    end else begin
      if (launch) begin
        mask_q    <= ch_mask;
        avg_cnt_q <= '0;
        idx_q     <= '0;
        arm_cnt_q <= '0;
        prev_q    <= SMIN;
        for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
      end else begin
        if (take) begin
          avg_cnt_q <= point ? '0 : avg_cnt_q + CNTW'(1);
          for (int c = 0; c < NCH; c++) acc_q[c] <= point ? '0 : sum[c];
          if (point) idx_q <= cap_done ? '0 : idx_q + IW'(1);
        end
        if (strobe_arm) begin
          prev_q    <= ch0;
          arm_cnt_q <= arm_cnt_q + 32'd1;
        end
      end
      hold_cnt_q <= (state_q == StHold) ? hold_cnt_q + 32'd1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (point) begin
      for (int c = 0; c < NCH; c++) mem[c][idx_q] <= ypt[c];
    end
  end

  // Walker issues one buffer address per cycle; the read lands directly in the output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wch_q       <= '0;
      wi_q        <= '0;
      wact_q      <= 1'b0;
      x           <= '0;
      y           <= '0;
      pen         <= '0;
      pixel_write <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      if (walk_load) begin
        wch_q  <= first_ch;
        wi_q   <= '0;
        wact_q <= (mask_q != '0);
      end else if (wact_q) begin
        if (wi_q == IDX_LAST) begin
          wi_q   <= '0;
          wact_q <= nxt_found;
          if (nxt_found) wch_q <= nxt_ch;
        end else begin
          wi_q <= wi_q + IW'(1);
        end
      end
      pixel_write <= wact_q && drawing;
      if (wact_q && drawing) begin
        x   <= 10'(wi_q);
        y   <= mem[wch_q][wi_q];
        pen <= (state_q == StDraw) ? PW'(wch_q) + PW'(1) : '0;
      end
      frame_done <= (state_q == StErase) && !wact_q;
    end
  end

endmodule

// File: tb/tb_multi_wave_plotter.sv
// Bench for multi_wave_plotter: constant-level vector table, trigger/timeout/reset sequences and
// randomized frames, each checked against a pixel list predicted from the plotting rules.
module tb_multi_wave_plotter;
  localparam int W    = 24;
  localparam int BS   = 4;
  localparam int HOLD = 3;
  localparam int ATO  = 5;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, enable = 1'b0;
  logic [2*W-1:0] samples = '0;
  logic [1:0]    ch_mask = '0;
  logic          trig_mode = 1'b0;
  logic [W-1:0]  trig_level = '0;
  logic [9:0]    x;
  logic [8:0]    y;
  logic [1:0]    pen;
  logic          pixel_write, busy, frame_done;

  multi_wave_plotter #(
    .WIDTH(W), .NCH(2), .BUFFER_SIZE(BS), .LOG2_AVG(1), .DIV(0), .Y_MID(240), .Y_MAX(479),
    .HOLD(HOLD), .ARM_TIMEOUT(ATO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .enable(enable), .samples(samples),
    .ch_mask(ch_mask), .trig_mode(trig_mode), .trig_level(trig_level), .x(x), .y(y),
    .pen(pen), .pixel_write(pixel_write), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int pen; int cyc; } pix_t;
  typedef struct { logic [1:0] mask; int a; int b; int y0; int y1; } vec_t;

  pix_t pix_q[$], exp_q[$];
  pix_t mon_p;
  int   s0[$], s1[$];
  int   ey[2][BS];
  int   n_vec = 0, n_err = 0, fd_cnt = 0, cyc = 0;
  vec_t tbl[8];

  always @(negedge clk) begin
    cyc++;
    if (pixel_write) begin
      mon_p.x = int'(x); mon_p.y = int'(y); mon_p.pen = int'(pen); mon_p.cyc = cyc;
      pix_q.push_back(mon_p);
    end
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Floor of s/2, i.e. the average of two samples rounded toward minus infinity.
  function automatic int floor_half(input int s);
    return (s >= 0) ? s / 2 : -((1 - s) / 2);
  endfunction

  function automatic int to_row(input int avg);
    int r;
    r = 240 - avg;
    if (r < 0) r = 0;
    if (r > 479) r = 479;
    return r;
  endfunction

  // Index of the first strobe accumulated after entering ARM.
  function automatic int trig_start(input int level);
    for (int k = 1; k < ATO; k++)
      if (s0[k-1] < level && s0[k] >= level) return k;
    return ATO;
  endfunction

  task automatic build_exp(input logic [1:0] mask);
    pix_t p;
    exp_q.delete();
    for (int pass = 0; pass < 2; pass++)
      for (int ch = 0; ch < 2; ch++)
        if (mask[ch])
          for (int i = 0; i < BS; i++) begin
            p.x = i; p.y = ey[ch][i]; p.pen = (pass == 0) ? ch + 1 : 0; p.cyc = 0;
            exp_q.push_back(p);
          end
  endtask

  task automatic model_frame(input logic [1:0] mask, input bit tm, input int level);
    int st;
    st = tm ? trig_start(level) : 0;
    for (int i = 0; i < BS; i++) begin
      ey[0][i] = to_row(floor_half(s0[st + 2*i] + s0[st + 2*i + 1]));
      ey[1][i] = to_row(floor_half(s1[st + 2*i] + s1[st + 2*i + 1]));
    end
    build_exp(mask);
  endtask

  task automatic start_frame(input logic [1:0] mask, input bit tm, input int level);
    pix_q.delete();
    fd_cnt = 0;
    @(negedge clk);
    ch_mask = mask; trig_mode = tm; trig_level = W'(level); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic feed();
    for (int k = 0; k < s0.size(); k++) begin
      repeat (3) @(negedge clk);
      samples = {W'(s1[k]), W'(s0[k])};
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
    end
  endtask

  task automatic finish_frame(input string tag);
    int t, n, nd, gap;
    t = 0;
    while (fd_cnt == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_frame_done_seen"}, int'(fd_cnt > 0), 1);
    repeat (3) @(negedge clk);
    check({tag, "_frame_done_once"}, fd_cnt, 1);
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_pixel_count"}, pix_q.size(), exp_q.size());
    n = (pix_q.size() < exp_q.size()) ? pix_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_px%0d_x", tag, i), pix_q[i].x, exp_q[i].x);
      check($sformatf("%s_px%0d_y", tag, i), pix_q[i].y, exp_q[i].y);
      check($sformatf("%s_px%0d_pen", tag, i), pix_q[i].pen, exp_q[i].pen);
    end
    nd = exp_q.size() / 2;
    if (pix_q.size() == exp_q.size() && nd > 0) begin
      check({tag, "_draw_span"}, pix_q[nd-1].cyc - pix_q[0].cyc, nd - 1);
      gap = pix_q[nd].cyc - pix_q[nd-1].cyc - 1;
      n_vec++;
      if (gap < HOLD || gap > HOLD + 1) begin
        n_err++;
        $display("FAIL %s_hold_gap: got %0d idle cycles, expected %0d..%0d", tag, gap, HOLD,
                 HOLD + 1);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [1:0] m;
    bit tm;
    int lv;

    #2;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_pen", pen, 0);
    check("rst_pixel_write", pixel_write, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    tbl[0] = '{2'b11, 10, -5, 230, 245};
    tbl[1] = '{2'b11, 1000, -1000, 0, 479};
    tbl[2] = '{2'b11, 0, 0, 240, 240};
    tbl[3] = '{2'b11, 241, -240, 0, 479};
    tbl[4] = '{2'b11, 239, -238, 1, 478};
    tbl[5] = '{2'b10, -1, 1, 241, 239};
    tbl[6] = '{2'b01, -100, 50, 340, 190};
    tbl[7] = '{2'b00, 5, 5, 235, 235};
    for (int v = 0; v < 8; v++) begin
      s0.delete(); s1.delete();
      for (int k = 0; k < 2 * BS; k++) begin
        s0.push_back(tbl[v].a);
        s1.push_back(tbl[v].b);
      end
      for (int i = 0; i < BS; i++) begin
        ey[0][i] = tbl[v].y0;
        ey[1][i] = tbl[v].y1;
      end
      build_exp(tbl[v].mask);
      start_frame(tbl[v].mask, 1'b0, 0);
      feed();
      finish_frame($sformatf("tbl%0d", v));
    end

    // Rising edge through 0 on the third strobe.
    s0 = '{-3, -1, 0, 5, 7, 9, 1, 1, 2, 2};
    s1 = '{0, 0, 4, 4, -8, -8, 6, 6, 0, 0};
    model_frame(2'b11, 1'b1, 0);
    start_frame(2'b11, 1'b1, 0);
    feed();
    finish_frame("trig");
    check("trig_first_y", (pix_q.size() > 0) ? pix_q[0].y : -1, 238);

    // No edge: free-runs after ATO strobes.
    s0 = '{-7, -7, -7, -7, -7, 20, 20, 20, 20, 20, 20, 20, 20};
    s1 = '{1, 2, 3, 4, 5, 6, 6, 8, 8, -2, -2, 0, 0};
    model_frame(2'b11, 1'b1, 0);
    start_frame(2'b11, 1'b1, 0);
    feed();
    finish_frame("timeout");
    check("timeout_first_y", (pix_q.size() > 0) ? pix_q[0].y : -1, 220);

    // Reset in the middle of DRAW, then a clean frame.
    s0 = '{30, 30, 30, 30, 30, 30, 30, 30};
    s1 = '{-30, -30, -30, -30, -30, -30, -30, -30};
    start_frame(2'b11, 1'b0, 0);
    feed();
    t = 0;
    while (!pixel_write && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("draw_reached", pixel_write, 1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_pixel_write", pixel_write, 0);
    check("rst_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_frame(2'b11, 1'b0, 0);
    start_frame(2'b11, 1'b0, 0);
    feed();
    finish_frame("after_rst");

    for (int r = 0; r < 8; r++) begin
      m  = 2'($urandom_range(0, 3));
      tm = 1'($urandom_range(0, 1));
      lv = int'($urandom_range(0, 200)) - 100;
      s0.delete(); s1.delete();
      for (int k = 0; k < ATO + 2 * BS + 1; k++) begin
        s0.push_back(int'($urandom_range(0, 300)) - 150);
        s1.push_back(int'($urandom_range(0, 1400)) - 700);
      end
      model_frame(m, tm, lv);
      start_frame(m, tm, lv);
      feed();
      finish_frame($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
